traffic_combinational: RTL and testbench
========================================

// Module: traffic_combinational
// PURPOSE
// - Light/timer decoder for a two-road (main/side) intersection controller.
// - Decodes the 2-bit Gray-coded phase i_G from the sequencer FSM into six lamp drives and two timer-start triggers.
// - Outputs are registered, with 1-cycle latency. Sits between the phase sequencer and the lamp drivers / long-short timer.
// PARAMETERS
// - TRIG_PULSE  0  0: triggers are levels held for the whole phase; 1: single-cycle pulse on the first cycle of a new phase.
// PORTS
// - i_clk            in   1  system clock, rising edge.
// - i_rst_n          in   1  reset, asynchronous assert, active-low.
// - i_G              in   2  phase code from the sequencer.
// - o_Main_red       out  1  main-road red lamp.
// - o_Main_yellow    out  1  main-road yellow lamp.
// - o_Main_green     out  1  main-road green lamp.
// - o_Side_red       out  1  side-road red lamp.
// - o_Side_yellow    out  1  side-road yellow lamp.
// - o_Side_green     out  1  side-road green lamp.
// - o_Long_trigger   out  1  start long timer (green phases).
// - o_Short_trigger  out  1  start short timer (yellow phases).
// - o_fault          out  1  sticky illegal-sequence flag; constant 0 unless the optional feature is compiled in.
// BEHAVIOUR
// - One clock and one reset. Reset is asynchronous and active-low.
// - Reset value: all-red failsafe.
//   - o_Main_red=1, o_Side_red=1.
//   - All other lamps = 0. Both triggers = 0. o_fault = 0.
// - Phase decode, registered on each rising i_clk. Outputs reflect i_G sampled at the previous edge.
//   - 00: Main green, Side red,    Long=1.
//   - 01: Main yellow, Side red,   Short=1.
//   - 11: Main red,   Side green,  Long=1.
//   - 10: Main red,   Side yellow, Short=1.
// - Default branch (any bit X/Z in simulation): all-red failsafe, both triggers 0.
// - Invariants:
//   - Exactly one lamp on per road.
//   - Never green or yellow on both roads at once.
//   - Long and Short are never both 1.
// - TRIG_PULSE=1: a trigger is 1 only in the cycle after i_G differs from the last registered phase. The first decode after reset counts as a change.
// - Reset mid-phase: outputs go to the failsafe immediately. The first edge after release decodes i_G normally.
// - Holding i_G constant is always legal: outputs stay stable.
// CONFIGURATION
// - Optional feature macro: TRAFFIC_COMB_SEQ_CHECK_EN.
// - Defined: a sequence checker is built in.
//   - Legal changes are 00->01->11->10->00 only. Holding a phase is also legal.
//   - Any other change (e.g. 00->11, 01->00) sets o_fault=1.
//   - While o_fault=1, all outputs are forced to the failsafe.
//   - o_fault is sticky until i_rst_n is asserted.
//   - The first sample after reset may be any code.
// - Undefined: no checker. o_fault is tied to 0 and every code is decoded independently.
// TESTING
// - Reset low, i_G=00 -> all-red, triggers 0; after release and 1 edge -> M_green=1, S_red=1, Long=1, Short=0.
// - Sequence 00,01,11,10 one edge apart -> M_yellow/S_red/Short, then M_red/S_green/Long, then M_red/S_yellow/Short, each 1 cycle later.
// - i_G=2'bxx -> all-red, Long=0, Short=0 next cycle; then i_G=11 -> S_green=1, Long=1.
// - TRIG_PULSE=1, hold i_G=01 for 5 edges -> Short=1 for exactly 1 cycle, lamps steady for all 5.
// - With TRAFFIC_COMB_SEQ_CHECK_EN: 00 then 11 -> o_fault=1, all-red; a later legal 01 keeps the fault; i_rst_n low clears it.
// - Assert i_rst_n low asynchronously mid-cycle during 11 -> failsafe without waiting for i_clk.

Source files
------------

// File: rtl/traffic_combinational.sv
// traffic_combinational: registered phase-to-lamp/trigger decoder for a main/side intersection.
// Define TRAFFIC_COMB_SEQ_CHECK_EN to build the sticky phase-sequence checker that drives o_fault.
module traffic_combinational #(
  parameter bit TRIG_PULSE = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_G,
  output logic       o_Main_red,
  output logic       o_Main_yellow,
  output logic       o_Main_green,
  output logic       o_Side_red,
  output logic       o_Side_yellow,
  output logic       o_Side_green,
  output logic       o_Long_trigger,
  output logic       o_Short_trigger,
  output logic       o_fault
);

  typedef struct packed {
    logic main_red;
    logic main_yellow;
    logic main_green;
    logic side_red;
    logic side_yellow;
    logic side_green;
    logic long_trig;
    logic short_trig;
  } drive_t;

  localparam drive_t FAILSAFE = 8'b100_100_00;
  localparam drive_t PH_00    = 8'b001_100_10;
  localparam drive_t PH_01    = 8'b010_100_01;
  localparam drive_t PH_11    = 8'b100_001_10;
  localparam drive_t PH_10    = 8'b100_010_01;

  drive_t     drv_q;
  drive_t     dec;
  drive_t     drv_d;
  logic [1:0] prev_g;
  logic       have_prev;
  logic       code_ok;
  logic       phase_chg;
  logic       fault_d;

  // Unknown codes fall to the failsafe and also forget the previous phase,
  // so the next valid code is treated as a fresh phase.
  always_comb begin
    dec     = FAILSAFE;
    code_ok = 1'b1;
    case (i_G)
      2'b00:   dec = PH_00;
      2'b01:   dec = PH_01;
      2'b11:   dec = PH_11;
      2'b10:   dec = PH_10;
      default: code_ok = 1'b0;
    endcase
    phase_chg = 1'b0;
    if (code_ok)
      phase_chg = !have_prev || (i_G != prev_g);
    if (TRIG_PULSE && !phase_chg) begin
      dec.long_trig  = 1'b0;
      dec.short_trig = 1'b0;
    end
  end

`ifdef TRAFFIC_COMB_SEQ_CHECK_EN
  logic fault_q;
  logic illegal;

  function automatic logic [1:0] next_phase(input logic [1:0] g);
    case (g)
      2'b00:   next_phase = 2'b01;
      2'b01:   next_phase = 2'b11;
      2'b11:   next_phase = 2'b10;
      default: next_phase = 2'b00;
    endcase
  endfunction

  always_comb begin
    illegal = 1'b0;
    if (code_ok && have_prev && phase_chg)
      illegal = (i_G != next_phase(prev_g));
  end

  // Fault takes effect on the same edge that sees the bad step.
  assign fault_d = fault_q | illegal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign o_fault = fault_q;
`else
  assign fault_d = 1'b0;
  assign o_fault = 1'b0;
`endif

  assign drv_d = fault_d ? FAILSAFE : dec;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drv_q     <= FAILSAFE;
      prev_g    <= 2'b00;
      have_prev <= 1'b0;
    end else begin
      drv_q     <= drv_d;
      prev_g    <= i_G;
      have_prev <= code_ok;
    end
  end

  assign o_Main_red      = drv_q.main_red;
  assign o_Main_yellow   = drv_q.main_yellow;
  assign o_Main_green    = drv_q.main_green;
  assign o_Side_red      = drv_q.side_red;
  assign o_Side_yellow   = drv_q.side_yellow;
  assign o_Side_green    = drv_q.side_green;
  assign o_Long_trigger  = drv_q.long_trig;
  assign o_Short_trigger = drv_q.short_trig;

endmodule

// File: tb/tb_traffic_combinational.sv
// Scoreboard bench: level-trigger (d0) and pulse-trigger (d1) decoders driven by one phase stream.
module tb_traffic_combinational;

  // {m_red,m_yel,m_grn, s_red,s_yel,s_grn, long,short, fault}
  localparam logic [8:0] FS   = 9'b100_100_00_0;
  localparam logic [8:0] FSF  = 9'b100_100_00_1;
  localparam logic [8:0] G00  = 9'b001_100_10_0;
  localparam logic [8:0] G01  = 9'b010_100_01_0;
  localparam logic [8:0] G01H = 9'b010_100_00_0;
  localparam logic [8:0] G11  = 9'b100_001_10_0;
  localparam logic [8:0] G10  = 9'b100_010_01_0;

  typedef struct {
    string      nm;
    logic [8:0] e0;
    logic [8:0] e1;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i_G;
  logic [1:0] gx;
  logic [8:0] out0, out1;
  exp_t       sb[$];
  exp_t       e_mon;
  int         n_chk = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  traffic_combinational #(.TRIG_PULSE(1'b0)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_G(i_G),
    .o_Main_red(out0[8]), .o_Main_yellow(out0[7]), .o_Main_green(out0[6]),
    .o_Side_red(out0[5]), .o_Side_yellow(out0[4]), .o_Side_green(out0[3]),
    .o_Long_trigger(out0[2]), .o_Short_trigger(out0[1]), .o_fault(out0[0])
  );

  traffic_combinational #(.TRIG_PULSE(1'b1)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_G(i_G),
    .o_Main_red(out1[8]), .o_Main_yellow(out1[7]), .o_Main_green(out1[6]),
    .o_Side_red(out1[5]), .o_Side_yellow(out1[4]), .o_Side_green(out1[3]),
    .o_Long_trigger(out1[2]), .o_Short_trigger(out1[1]), .o_fault(out1[0])
  );

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk({e_mon.nm, "/level"}, out0, e_mon.e0);
      chk({e_mon.nm, "/pulse"}, out1, e_mon.e1);
    end
  end

  task automatic drive(input logic [1:0] g, input logic [8:0] e0, input logic [8:0] e1,
                       input string nm);
    exp_t e;
    i_G = g;
    e.nm = nm; e.e0 = e0; e.e1 = e1;
    sb.push_back(e);
  endtask

  task automatic step(input logic [1:0] g, input logic [8:0] e0, input logic [8:0] e1,
                      input string nm);
    @(negedge clk); #1;
    drive(g, e0, e1, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    i_G   = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset/level", out0, FS);
    chk("reset/pulse", out1, FS);

    rst_n = 1'b1;
    drive(2'b00, G00, G00, "first");
    step(2'b01, G01, G01, "seq01");
    step(2'b11, G11, G11, "seq11");
    step(2'b10, G10, G10, "seq10");
    step(2'b00, G00, G00, "wrap00");

    gx = 2'bxx;
    if ($isunknown(gx)) begin
      step(gx, FS, FS, "unknown");
      step(2'b11, G11, G11, "after_unknown");
    end else begin
      step(2'b01, G01, G01, "alt01");
      step(2'b11, G11, G11, "alt11");
    end

    step(2'b10, G10, G10, "seq10b");
    step(2'b00, G00, G00, "seq00b");
    step(2'b01, G01, G01, "enter01");
    repeat (4) step(2'b01, G01, G01H, "hold01");
    step(2'b11, G11, G11, "pre_async");

    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst/level", out0, FS);
    chk("async_rst/pulse", out1, FS);

    @(negedge clk); #1;
    rst_n = 1'b1;
    drive(2'b11, G11, G11, "post_rst");
    step(2'b10, G10, G10, "seq10c");
    step(2'b00, G00, G00, "seq00c");

`ifdef TRAFFIC_COMB_SEQ_CHECK_EN
    step(2'b11, FSF, FSF, "illegal_00_11");
    step(2'b01, FSF, FSF, "sticky");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("fault_clear/level", out0, FS);
    chk("fault_clear/pulse", out1, FS);
    @(negedge clk); #1;
    rst_n = 1'b1;
    drive(2'b01, G01, G01, "post_clear");
`else
    step(2'b11, G11, G11, "jump_00_11");
    step(2'b01, G01, G01, "jump_11_01");
`endif

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries pending, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
